// File: rtl/itype_exec_arbiter_pkg.sv
// Shared constants and types for the dual-issue I-type execute arbiter.
// Datapath bounds, opcode/funct7 constants, slot state and request payload.
package itype_exec_arbiter_pkg;

    localparam int MSB     = 31;
    localparam int LSB     = 0;
    localparam int XLEN    = MSB - LSB + 1;
    localparam int RD_W    = 5;
    localparam int INSTR_W = 32;

    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] F7_SRL    = 7'b0000000;
    localparam logic [6:0] F7_SRA    = 7'b0100000;
    localparam logic [2:0] F3_SLLI   = 3'b001;
    localparam logic [2:0] F3_SRXI   = 3'b101;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    rv1;
        logic [XLEN-1:0]    imm;
        logic [RD_W-1:0]    rd;
    } itype_req_t;

    // Flags anything the I-type unit cannot execute: foreign opcodes and
    // shift-immediates with a funct7 the unit does not decode.
    function automatic logic itype_illegal(input logic [INSTR_W-1:0] instr);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = instr[31:25];
        f3 = instr[14:12];
        itype_illegal = (instr[6:0] != OPC_ITYPE)
                     || ((f3 == F3_SLLI) && (f7 != F7_SRL))
                     || ((f3 == F3_SRXI) && (f7 != F7_SRL) && (f7 != F7_SRA));
    endfunction

endpackage

// File: rtl/itype_exec_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant. Purely combinational; the owner keeps
// the last_grant register and loads it from last_grant_nxt every cycle.
module rr_arb2
    import itype_exec_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last_grant_nxt
);

    // One-hot grant: a lone requester wins, a tie goes to the port that lost last time.
    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        last_grant_nxt = (advance && (grant != 2'b00)) ? grant[1] : last_grant;
    end

endmodule

// File: rtl/itype_exec_arbiter.sv
// itype_exec_arbiter: shares one combinational I-type execute unit between two
// issue ports with round-robin arbitration and a one-deep response slot.
// Optional illegal-instruction flag enabled by defining ITYPE_EXEC_ILLEGAL_CHK_EN.
module itype_exec_arbiter
    import itype_exec_arbiter_pkg::*;
#(
    parameter int MSB  = itype_exec_arbiter_pkg::MSB,
    parameter int LSB  = itype_exec_arbiter_pkg::LSB,
    parameter int RD_W = itype_exec_arbiter_pkg::RD_W
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][31:0]           req_instr,
    input  logic [1:0][MSB-LSB:0]      req_rv1,
    input  logic [1:0][MSB-LSB:0]      req_imm,
    input  logic [1:0][RD_W-1:0]       req_rd,
    output logic [31:0]                alu_instr,
    output logic [MSB-LSB:0]           alu_rv1,
    output logic [MSB-LSB:0]           alu_imm,
    input  logic [MSB-LSB:0]           alu_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_port,
    output logic [RD_W-1:0]            rsp_rd,
    output logic [MSB-LSB:0]           rsp_data
`ifdef ITYPE_EXEC_ILLEGAL_CHK_EN
    ,
    output logic                       rsp_illegal
`endif
);

    slot_state_t           state, state_nxt;
    logic                  last_grant, last_grant_nxt;
    logic [1:0]            grant;
    logic                  slot_free;
    logic                  accept;
    logic                  acc_port;
    itype_req_t            sel;
    logic                  cap_illegal;
    logic [MSB-LSB:0]      cap_data;

    rr_arb2 u_arb (
        .valid          (req_valid),
        .last_grant     (last_grant),
        .advance        (accept),
        .grant          (grant),
        .last_grant_nxt (last_grant_nxt)
    );

    // Slot can take a new result when empty or when the current one drains this cycle.
    always_comb begin
        slot_free = (state == EMPTY) || rsp_ready;
        req_ready = grant & {2{slot_free & ~reset}};
        accept    = |(req_valid & req_ready);
        acc_port  = req_ready[1];
    end

    // Steer the granted port's payload onto the shared unit; idle bus is all zero.
    always_comb begin
        sel = '0;
        if (grant[0]) begin
            sel.instr = req_instr[0];
            sel.rv1   = req_rv1[0];
            sel.imm   = req_imm[0];
            sel.rd    = req_rd[0];
        end else if (grant[1]) begin
            sel.instr = req_instr[1];
            sel.rv1   = req_rv1[1];
            sel.imm   = req_imm[1];
            sel.rd    = req_rd[1];
        end
        alu_instr = sel.instr;
        alu_rv1   = sel.rv1;
        alu_imm   = sel.imm;
    end

    // Result to capture: x0 writes and illegal instructions always deliver zero.
    always_comb begin
`ifdef ITYPE_EXEC_ILLEGAL_CHK_EN
        cap_illegal = itype_illegal(sel.instr);
`else
        cap_illegal = 1'b0;
`endif
        cap_data = ((sel.rd == '0) || cap_illegal) ? '0 : alu_result;
    end

    // Slot next-state: reloading while draining keeps the slot FULL with no bubble.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Slot state and round-robin pointer; pointer starts at 1 so port 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Response register: loads only on an accept, otherwise holds for writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_port <= 1'b0;
            rsp_rd   <= '0;
            rsp_data <= '0;
        end else if (accept) begin
            rsp_port <= acc_port;
            rsp_rd   <= sel.rd;
            rsp_data <= cap_data;
        end
    end

`ifdef ITYPE_EXEC_ILLEGAL_CHK_EN
    // Illegal flag travels with the response it describes.
    always_ff @(posedge clk) begin
        if (reset)       rsp_illegal <= 1'b0;
        else if (accept) rsp_illegal <= cap_illegal;
    end
`endif

    assign rsp_valid = (state == FULL);

endmodule
